// File: rtl/banked_mem_if.sv
// Bus bundle for banked_mem: clear request, write port, read port and status.
// The memory side uses the slave modport; the loader/core side uses master.
interface banked_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  clr_req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr_w;
  logic [DATA_W-1:0]     data_in;
  logic                  re;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     data_out;
  logic                  rvalid;
  logic                  busy;

  modport master (
    output clr_req, we, be, addr_w, data_in, re, addr_r,
    input  data_out, rvalid, busy
  );

  modport slave (
    input  clr_req, we, be, addr_w, data_in, re, addr_r,
    output data_out, rvalid, busy
  );
endinterface

// File: rtl/banked_mem.sv
// banked_mem: single-write / single-read synchronous memory with byte enables,
// a 1- or 2-cycle read pipeline, selectable read-during-write behaviour and a
// hardware clear sweep that runs after reset and on request (busy while active).
module banked_mem #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 1024,
  parameter int                RD_PIPE  = 0,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        clr_n,
  banked_mem_if.slave bus
);

  localparam int                NB        = DATA_W / 8;
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic              same_addr;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] rd_word;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  // Replace the bytes selected by be_i, keep the rest of the old word.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be_i
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be_i[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // A clear request takes priority over any write/read in the same cycle.
  assign idle        = (state == ST_IDLE);
  assign wr_in_range = ({1'b0, bus.addr_w} < DEPTH_L);
  assign rd_in_range = ({1'b0, bus.addr_r} < DEPTH_L);
  assign wr_acc      = idle && !bus.clr_req && bus.we && wr_in_range;
  assign rd_acc      = idle && !bus.clr_req && bus.re;
  assign same_addr   = (bus.addr_w == bus.addr_r);

  // Clear sweep: INIT_VAL to one word per edge; IDLE <-> CLEAR on completion/request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clr_req) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_CLEAR;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and the user write path.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    mem_we    = 1'b0;
    mem_idx   = bus.addr_w[IDX_W-1:0];
    mem_wdata = bus.data_in;
    mem_be    = bus.be;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = cnt[IDX_W-1:0];
      mem_wdata = INIT_VAL;
      mem_be    = '1;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // Storage array update.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term so it maps onto RAM; its contents
    // are initialised by the clear sweep instead.
    if (mem_we) mem[mem_idx] <= byte_merge(mem[mem_idx], mem_wdata, mem_be);
  end

  // Read word: out-of-range reads give 0; RDW_MODE=1 forwards same-cycle write bytes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.addr_r[IDX_W-1:0]];
      if ((RDW_MODE != 0) && wr_acc && same_addr)
        rd_word = byte_merge(rd_word, bus.data_in, bus.be);
    end
  end

  // First read stage: capture accepted reads; data holds between reads.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_pipe2
      logic              s2_valid;
      logic [DATA_W-1:0] s2_data;

      // Optional second read stage for a 2-cycle latency.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign bus.data_out = s2_data;
      assign bus.rvalid   = s2_valid;
    end else begin : g_pipe1
      assign bus.data_out = s1_data;
      assign bus.rvalid   = s1_valid;
    end
  endgenerate

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem. Two instances run the same stimulus:
// dut_a (1-cycle read, old-data RDW, INIT 0) and dut_b (2-cycle read,
// new-data RDW, INIT A5A55A5A). DEPTH=16 with ADDR_W=5 exposes out-of-range addresses.
module tb_banked_mem;

  localparam logic [31:0] INIT_A = 32'h0000_0000;
  localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;

  logic clk;
  logic clr_n;
  int   cyc;
  int   tests;
  int   errors;

  rd_t qa[$];
  rd_t qb[$];
  rd_t ea[$];
  rd_t eb[$];

  banked_mem_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  banked_mem_if #(.DATA_W(32), .ADDR_W(5)) ib ();

  assign ib.clr_req = ia.clr_req;
  assign ib.we      = ia.we;
  assign ib.be      = ia.be;
  assign ib.addr_w  = ia.addr_w;
  assign ib.data_in = ia.data_in;
  assign ib.re      = ia.re;
  assign ib.addr_r  = ia.addr_r;

  banked_mem #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_PIPE(0), .RDW_MODE(0), .INIT_VAL(INIT_A)
  ) dut_a (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (ia.slave)
  );

  banked_mem #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_PIPE(1), .RDW_MODE(1), .INIT_VAL(INIT_B)
  ) dut_b (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (ib.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rd_t mk(input int c, input logic [31:0] d);
    rd_t r;
    r.cyc  = c;
    r.data = d;
    return r;
  endfunction

  // Record every rvalid pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (ia.rvalid) qa.push_back(mk(cyc, ia.data_out));
    if (ib.rvalid) qb.push_back(mk(cyc, ib.data_out));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    ia.we = 1'b1; ia.addr_w = a; ia.data_in = d; ia.be = be;
    tick();
    ia.we = 1'b0;
  endtask

  // Issue a read; xa/xb are the hand-computed results for dut_a/dut_b.
  task automatic rd(input logic [4:0] a, input logic [31:0] xa, input logic [31:0] xb);
    ia.re = 1'b1; ia.addr_r = a;
    ea.push_back(mk(cyc + 1, xa));
    eb.push_back(mk(cyc + 2, xb));
    tick();
    ia.re = 1'b0;
  endtask

  // Same-cycle write and read.
  task automatic rw(input logic [4:0] wa, input logic [31:0] d, input logic [3:0] be,
                    input logic [4:0] ra, input logic [31:0] xa, input logic [31:0] xb);
    ia.we = 1'b1; ia.addr_w = wa; ia.data_in = d; ia.be = be;
    ia.re = 1'b1; ia.addr_r = ra;
    ea.push_back(mk(cyc + 1, xa));
    eb.push_back(mk(cyc + 2, xb));
    tick();
    ia.we = 1'b0;
    ia.re = 1'b0;
  endtask

  // Let the pipelines empty, then compare observed reads against expectations.
  task automatic drain(input string name);
    int n;
    repeat (4) tick();
    check({name, "_a_count"}, qa.size(), ea.size());
    n = (qa.size() < ea.size()) ? qa.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_a%0d_data", name, i), qa[i].data, ea[i].data);
      check($sformatf("%s_a%0d_cyc", name, i), qa[i].cyc, ea[i].cyc);
    end
    check({name, "_b_count"}, qb.size(), eb.size());
    n = (qb.size() < eb.size()) ? qb.size() : eb.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d_data", name, i), qb[i].data, eb[i].data);
      check($sformatf("%s_b%0d_cyc", name, i), qb[i].cyc, eb[i].cyc);
    end
    qa.delete(); qb.delete(); ea.delete(); eb.delete();
  endtask

  // Count edges until busy falls (bounded); optionally pulse clr_req mid-sweep.
  task automatic count_busy(input string name, input int pulse_at);
    int na;
    int nb;
    na = -1;
    nb = -1;
    for (int n = 1; n <= 64; n++) begin
      if (n == pulse_at) ia.clr_req = 1'b1;
      tick();
      ia.clr_req = 1'b0;
      if (na < 0 && !ia.busy) na = n;
      if (nb < 0 && !ib.busy) nb = n;
      if (na >= 0 && nb >= 0) break;
    end
    check({name, "_a_busy_cycles"}, na, 16);
    check({name, "_b_busy_cycles"}, nb, 16);
  endtask

  initial begin
    tests   = 0;
    errors  = 0;
    cyc     = 0;
    clr_n   = 1'b0;
    ia.clr_req = 1'b0;
    ia.we      = 1'b0;
    ia.be      = '0;
    ia.addr_w  = '0;
    ia.data_in = '0;
    ia.re      = 1'b0;
    ia.addr_r  = '0;

    // Reset state.
    #23;
    check("rst_a_data", ia.data_out, 32'h0);
    check("rst_a_rvalid", ia.rvalid, 1'b0);
    check("rst_a_busy", ia.busy, 1'b1);
    check("rst_b_data", ib.data_out, 32'h0);
    check("rst_b_rvalid", ib.rvalid, 1'b0);
    check("rst_b_busy", ib.busy, 1'b1);

    // Initial sweep with a write to the already-cleared word 0 and a read held
    // high throughout: both must be dropped.
    clr_n = 1'b1;
    ia.we = 1'b1; ia.addr_w = 5'd0; ia.data_in = 32'hFFFF_FFFF; ia.be = 4'hF;
    ia.re = 1'b1; ia.addr_r = 5'd3;
    count_busy("sweep", 0);
    ia.we = 1'b0;
    ia.re = 1'b0;
    drain("sweep_reads");

    // Every word holds INIT_VAL after the sweep.
    for (int i = 0; i < 16; i++) rd(5'(i), INIT_A, INIT_B);
    drain("init_all");

    // Full-word writes and back-to-back reads.
    wr(5'd0, 32'hAAAA_BBBB, 4'hF);
    wr(5'd1, 32'h1234_5678, 4'hF);
    wr(5'd2, 32'hDEAD_BEEF, 4'hF);
    rd(5'd0, 32'hAAAA_BBBB, 32'hAAAA_BBBB);
    rd(5'd1, 32'h1234_5678, 32'h1234_5678);
    rd(5'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drain("b2b");

    // Partial byte-enable write.
    wr(5'd1, 32'hFFFF_0000, 4'b0011);
    rd(5'd1, 32'h1234_0000, 32'h1234_0000);
    drain("byte_en");

    // Read-during-write, out-of-range write, be=0 write, out-of-range reads.
    wr(5'd5, 32'h1111_1111, 4'hF);
    rw(5'd5, 32'hDEAD_BEEF, 4'hF, 5'd5, 32'h1111_1111, 32'hDEAD_BEEF);
    rd(5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rw(5'd5, 32'h0000_00AA, 4'b0001, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEAA);
    rw(5'd6, 32'hCAFE_F00D, 4'hF, 5'd5, 32'hDEAD_BEAA, 32'hDEAD_BEAA);
    rd(5'd6, 32'hCAFE_F00D, 32'hCAFE_F00D);
    wr(5'd16, 32'h9999_9999, 4'hF);
    wr(5'd2, 32'h0000_0000, 4'h0);
    rd(5'd0, 32'hAAAA_BBBB, 32'hAAAA_BBBB);
    rd(5'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rd(5'd16, 32'h0, 32'h0);
    rd(5'd31, 32'h0, 32'h0);
    drain("rdw_range");

    // Clear request: earlier read completes with old data; same-cycle
    // write/read dropped; writes during busy and a second clr_req ignored.
    rd(5'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ia.clr_req = 1'b1;
    ia.we = 1'b1; ia.addr_w = 5'd0; ia.data_in = 32'h5555_5555; ia.be = 4'hF;
    ia.re = 1'b1; ia.addr_r = 5'd1;
    tick();
    ia.clr_req = 1'b0;
    ia.re = 1'b0;
    check("clr_a_busy", ia.busy, 1'b1);
    check("clr_b_busy", ib.busy, 1'b1);
    ia.data_in = 32'h7777_7777;
    count_busy("clr", 6);
    ia.we = 1'b0;
    drain("clr_pending");
    rd(5'd0, INIT_A, INIT_B);
    rd(5'd1, INIT_A, INIT_B);
    rd(5'd2, INIT_A, INIT_B);
    rd(5'd5, INIT_A, INIT_B);
    drain("after_clr");

    // Output held between reads.
    wr(5'd4, 32'h1212_1212, 4'hF);
    rd(5'd4, 32'h1212_1212, 32'h1212_1212);
    drain("load4");
    check("hold_a_data", ia.data_out, 32'h1212_1212);
    check("hold_a_rvalid", ia.rvalid, 1'b0);
    check("hold_b_data", ib.data_out, 32'h1212_1212);
    check("hold_b_rvalid", ib.rvalid, 1'b0);

    // Reset asserted mid-sweep: outputs clear, sweep restarts for full DEPTH.
    ia.clr_req = 1'b1;
    tick();
    ia.clr_req = 1'b0;
    repeat (5) tick();
    #2 clr_n = 1'b0;
    #1;
    check("midrst_a_data", ia.data_out, 32'h0);
    check("midrst_a_rvalid", ia.rvalid, 1'b0);
    check("midrst_a_busy", ia.busy, 1'b1);
    check("midrst_b_data", ib.data_out, 32'h0);
    check("midrst_b_rvalid", ib.rvalid, 1'b0);
    check("midrst_b_busy", ib.busy, 1'b1);
    @(posedge clk);
    #3 clr_n = 1'b1;
    count_busy("midrst", 0);
    rd(5'd4, INIT_A, INIT_B);
    rd(5'd16, 32'h0, 32'h0);
    rd(5'd0, INIT_A, INIT_B);
    drain("after_midrst");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
